cpu_control: RTL and testbench

Multi-cycle sequencer for the 16-bit CPU core. It steps every instruction through fetch, decode, register read, ALU execute, optional memory access and writeback. It drives the enable strobes of the decoder, register file and ALU, and owns the single memory request/acknowledge handshake shared by instruction fetch and data access. It sits at the top of the core, beside the ALU, and uses the ALU's registered write-rD, write-PC and memory-mode results to choose the tail of each instruction.

---
 rtl/cpu_control_if.sv | 30 +++
 rtl/cpu_control.sv | 167 ++++++++++++++++
 tb/tb_cpu_control.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_if.sv
// -----------------------------------------------------------------------------
// cpu_control_if
// Memory request/acknowledge handshake shared by instruction fetch and data
// access.
//   O_mem_req   : request pending (held until acknowledged)
//   O_mem_we    : request is a write
//   O_addr_sel  : 0 = address from PC, 1 = address from ALU result
//   I_mem_ack   : memory acknowledge for the current request
// The controller uses the master modport; the memory side uses slave.
// -----------------------------------------------------------------------------
interface cpu_control_if;
  logic O_mem_req;
  logic O_mem_we;
  logic O_addr_sel;
  logic I_mem_ack;

  modport master (
    output O_mem_req,
    output O_mem_we,
    output O_addr_sel,
    input  I_mem_ack
  );

  modport slave (
    input  O_mem_req,
    input  O_mem_we,
    input  O_addr_sel,
    output I_mem_ack
  );
endinterface

// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
// Multi-cycle sequencer for the 16-bit CPU core. Steps each instruction through
// FETCH, DECODE, REGREAD, EXECUTE, MEMORY and WRITEBACK, driving the one-cycle
// enable strobes of decoder, register file and ALU, and owning the memory
// handshake. Memory waits are bounded by MEM_TIMEOUT (1..255); an expired wait
// parks the controller in FAULT until reset.
// Ports:
//   I_clk, I_reset           : clock, synchronous active-high reset
//   I_enable                 : run gate; low freezes state and counters
//   I_halt                   : halt request, sampled in WRITEBACK only
//   mem                      : memory handshake (cpu_control_if.master)
//   I_alu_write_rD/_pc       : registered ALU writeback targets
//   I_alu_memory_mode        : 0 = NOP, 1 = READ, 2 = WRITE (3 behaves as NOP)
//   O_state                  : current state code
//   O_ir_load                : latch fetched word into IR
//   O_decoder/regfile/alu_enable : per-stage strobes
//   O_reg_write, O_wb_sel    : register write strobe and writeback source
//   O_pc_write, O_pc_inc     : PC load from ALU / PC increment
//   O_retired                : retired-instruction count (wraps)
//   O_fault                  : memory-timeout fault (sticky until reset)
// -----------------------------------------------------------------------------
module cpu_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic          I_clk,
  input  logic          I_reset,
  input  logic          I_enable,
  input  logic          I_halt,
  cpu_control_if.master mem,
  input  logic          I_alu_write_rD,
  input  logic          I_alu_write_pc,
  input  logic [1:0]    I_alu_memory_mode,
  output logic [2:0]    O_state,
  output logic          O_ir_load,
  output logic          O_decoder_enable,
  output logic          O_regfile_enable,
  output logic          O_alu_enable,
  output logic          O_reg_write,
  output logic          O_wb_sel,
  output logic          O_pc_write,
  output logic          O_pc_inc,
  output logic [15:0]   O_retired,
  output logic          O_fault
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_REGREAD   = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  // Last wait-count value at which an ack still completes the transfer.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic        r_run;       // low for the cycle right after reset: no request yet
  logic        r_wb_sel;
  logic [15:0] r_retired;
  logic        w_mem_req;
  logic        w_mem_access;
  logic        w_timeout;

  assign w_mem_access = (I_alu_memory_mode == MEM_READ) ||
                        (I_alu_memory_mode == MEM_WRITE);
  assign w_timeout    = (r_wait_cnt == WAIT_LAST);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state     = r_state;
    w_mem_req        = 1'b0;
    mem.O_mem_we     = 1'b0;
    mem.O_addr_sel   = 1'b0;
    O_ir_load        = 1'b0;
    O_decoder_enable = 1'b0;
    O_regfile_enable = 1'b0;
    O_alu_enable     = 1'b0;
    O_reg_write      = 1'b0;
    O_wb_sel         = 1'b0;
    O_pc_write       = 1'b0;
    O_pc_inc         = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_run) begin
          w_mem_req = 1'b1;
          // Gate with I_enable so a frozen cycle never loads IR twice.
          O_ir_load = mem.I_mem_ack & I_enable;
          if (mem.I_mem_ack)  w_next_state = S_DECODE;
          else if (w_timeout) w_next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        O_decoder_enable = 1'b1;
        w_next_state     = S_REGREAD;
      end
      S_REGREAD: begin
        O_regfile_enable = 1'b1;
        w_next_state     = S_EXECUTE;
      end
      S_EXECUTE: begin
        O_alu_enable = 1'b1;
        w_next_state = S_MEMORY;
      end
      S_MEMORY: begin
        if (w_mem_access) begin
          w_mem_req      = 1'b1;
          mem.O_addr_sel = 1'b1;
          mem.O_mem_we   = (I_alu_memory_mode == MEM_WRITE);
          // An ack in the timeout cycle still wins over the fault.
          if (mem.I_mem_ack)  w_next_state = S_WRITEBACK;
          else if (w_timeout) w_next_state = S_FAULT;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        O_reg_write  = I_alu_write_rD;
        O_wb_sel     = r_wb_sel;
        O_pc_write   = I_alu_write_pc;
        O_pc_inc     = ~I_alu_write_pc;
        w_next_state = I_halt ? S_HALT : S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
      r_run      <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_retired  <= 16'd0;
    end else if (I_enable) begin
      r_run   <= 1'b1;
      r_state <= w_next_state;
      if ((w_next_state != r_state) &&
          ((w_next_state == S_FETCH) || (w_next_state == S_MEMORY)))
        r_wait_cnt <= 8'd0;
      else if (w_mem_req && !mem.I_mem_ack)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      // First MEMORY cycle: the wait count is still zero there.
      if ((r_state == S_MEMORY) && (r_wait_cnt == 8'd0))
        r_wb_sel <= (I_alu_memory_mode == MEM_READ);
      if (r_state == S_WRITEBACK)
        r_retired <= r_retired + 16'd1;
    end
  end

  assign mem.O_mem_req = w_mem_req;
  assign O_state       = r_state;
  assign O_retired     = r_retired;
  assign O_fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// tb_cpu_control
// Self-checking bench for cpu_control. Each instruction is described by its
// memory mode, writeback targets, fetch/memory ack delays and halt request;
// the bench expands that description into the per-cycle output sequence the
// controller must produce and compares every cycle, optionally with run-gate
// gaps inserted.
// -----------------------------------------------------------------------------
module tb_cpu_control;
  localparam int T = 4;  // MEM_TIMEOUT used for this bench

  logic        I_clk = 1'b0;
  logic        I_reset, I_enable, I_halt;
  logic        I_alu_write_rD, I_alu_write_pc;
  logic [1:0]  I_alu_memory_mode;
  logic [2:0]  O_state;
  logic        O_ir_load, O_decoder_enable, O_regfile_enable, O_alu_enable;
  logic        O_reg_write, O_wb_sel, O_pc_write, O_pc_inc, O_fault;
  logic [15:0] O_retired;

  cpu_control_if mem_if ();

  cpu_control #(.MEM_TIMEOUT(T)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_enable(I_enable), .I_halt(I_halt),
    .mem(mem_if),
    .I_alu_write_rD(I_alu_write_rD), .I_alu_write_pc(I_alu_write_pc),
    .I_alu_memory_mode(I_alu_memory_mode),
    .O_state(O_state), .O_ir_load(O_ir_load),
    .O_decoder_enable(O_decoder_enable), .O_regfile_enable(O_regfile_enable),
    .O_alu_enable(O_alu_enable), .O_reg_write(O_reg_write), .O_wb_sel(O_wb_sel),
    .O_pc_write(O_pc_write), .O_pc_inc(O_pc_inc), .O_retired(O_retired),
    .O_fault(O_fault)
  );

  always #5 I_clk = ~I_clk;

  // Expected output word for one cycle (retired count kept separately).
  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, irl, dec, rf, alu, rw, wbs, pcw, pci, flt;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    ack;     // value driven on I_mem_ack in this cycle
    bit    halt;    // value driven on I_halt in this cycle
    bit    retire;  // instruction retires at the end of this cycle
    bit    term;    // HALT/FAULT: sequence ends here
  } rec_t;

  rec_t        q[$];
  bit   [15:0] m_retired;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic rec_t new_rec(input int st);
    rec_t r;
    r.o      = '0;
    r.o.st   = 3'(st);
    r.o.flt  = (st == 7);
    r.ack    = 1'($urandom_range(0, 1));  // ignored whenever no request is up
    r.halt   = 1'($urandom_range(0, 1));  // ignored outside WRITEBACK
    r.retire = 1'b0;
    r.term   = (st >= 6);
    return r;
  endfunction

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check(input string tag, input outs_t eo, input bit [15:0] er);
    logic [30:0] act, exp_v;
    @(negedge I_clk);
    act   = {O_state, mem_if.O_mem_req, mem_if.O_mem_we, mem_if.O_addr_sel,
             O_ir_load, O_decoder_enable, O_regfile_enable, O_alu_enable,
             O_reg_write, O_wb_sel, O_pc_write, O_pc_inc, O_fault, O_retired};
    exp_v = {eo, er};
    vectors++;
    assert (act === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic plan(input int mode, input bit wr, input bit wp,
                      input int df, input int dm, input bit h);
    rec_t r;
    bit   acc;
    I_alu_memory_mode = 2'(mode);
    I_alu_write_rD    = wr;
    I_alu_write_pc    = wp;
    for (int k = 0; k <= df && k < T; k++) begin
      r = new_rec(0);
      r.o.req = 1'b1;
      r.ack   = (k == df);
      r.o.irl = r.ack;
      q.push_back(r);
    end
    if (df >= T) begin q.push_back(new_rec(7)); return; end
    r = new_rec(1); r.o.dec = 1'b1; q.push_back(r);
    r = new_rec(2); r.o.rf  = 1'b1; q.push_back(r);
    r = new_rec(3); r.o.alu = 1'b1; q.push_back(r);
    acc = (mode == 1) || (mode == 2);
    if (!acc) q.push_back(new_rec(4));
    else begin
      for (int k = 0; k <= dm && k < T; k++) begin
        r = new_rec(4);
        r.o.req  = 1'b1;
        r.o.asel = 1'b1;
        r.o.we   = (mode == 2);
        r.ack    = (k == dm);
        q.push_back(r);
      end
      if (dm >= T) begin q.push_back(new_rec(7)); return; end
    end
    r = new_rec(5);
    r.o.rw  = wr;
    r.o.wbs = (mode == 1);
    r.o.pcw = wp;
    r.o.pci = !wp;
    r.halt  = h;
    r.retire = 1'b1;
    q.push_back(r);
    if (h) q.push_back(new_rec(6));
  endtask

  // Drive one expected cycle, preceded by 'gap' run-gate-low cycles in which
  // the state (and so the outputs) must hold; IR load never fires while off.
  task automatic apply(input rec_t r, input int gap, input string tag);
    outs_t d;
    d = r.o;
    d.irl = 1'b0;
    for (int i = 0; i < gap; i++) begin
      I_enable         = 1'b0;
      mem_if.I_mem_ack = 1'($urandom_range(0, 1));
      I_halt           = 1'($urandom_range(0, 1));
      check({tag, "/frozen"}, d, m_retired);
      tick();
    end
    I_enable         = 1'b1;
    mem_if.I_mem_ack = r.ack;
    I_halt           = r.halt;
    check(tag, r.o, m_retired);
    tick();
    if (r.retire) m_retired++;
  endtask

  // gap_mode: 0 none, 1 random gaps, 2 five-cycle gaps in EXECUTE and pending FETCH
  task automatic run_queue(input string tag, input int gap_mode, output bit ended);
    rec_t r;
    int   gap;
    ended = 1'b0;
    while (q.size() > 0) begin
      r   = q.pop_front();
      gap = 0;
      if (gap_mode == 1 && $urandom_range(0, 7) == 0) gap = $urandom_range(1, 5);
      if (gap_mode == 2 && (r.o.st == 3'd3 || (r.o.st == 3'd0 && !r.ack))) gap = 5;
      apply(r, gap, tag);
      if (r.term) begin
        for (int i = 0; i < 3; i++) begin
          r.ack  = 1'($urandom_range(0, 1));
          r.halt = 1'($urandom_range(0, 1));
          apply(r, (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0, {tag, "/hold"});
        end
        ended = 1'b1;
      end
    end
  endtask

  // Reset (with the run gate at random, since reset overrides it), then the
  // first post-reset cycle: FETCH with every strobe and the request still low.
  task automatic do_reset();
    I_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      I_enable         = 1'($urandom_range(0, 1));
      mem_if.I_mem_ack = 1'($urandom_range(0, 1));
      I_halt           = 1'($urandom_range(0, 1));
      tick();
    end
    I_reset          = 1'b0;
    I_enable         = 1'b1;
    mem_if.I_mem_ack = 1'($urandom_range(0, 1));
    m_retired        = 16'h0000;
    check("reset", outs_t'(0), 16'h0000);
    tick();
  endtask

  initial begin
    bit   ended;
    rec_t r;
    int   mode, df, dm;
    I_reset = 1'b1; I_enable = 1'b0; I_halt = 1'b0; mem_if.I_mem_ack = 1'b0;
    I_alu_write_rD = 1'b0; I_alu_write_pc = 1'b0; I_alu_memory_mode = 2'd0;

    do_reset();
    // ADD, ack immediate: states 0..5 then back to FETCH
    plan(0, 1, 0, 0, 0, 0);  run_queue("add", 0, ended);
    // READ with ack three cycles late in MEMORY
    plan(1, 1, 0, 0, 3, 0);  run_queue("read", 0, ended);
    // JMP: PC load, no register write
    plan(0, 0, 1, 0, 0, 0);  run_queue("jmp", 0, ended);
    // WRITE with one wait cycle
    plan(2, 0, 0, 0, 1, 0);  run_queue("write", 0, ended);
    // Fetch never acknowledged: fault after T request cycles
    plan(0, 1, 0, T, 0, 0);  run_queue("fetch_timeout", 0, ended);
    do_reset();
    // Ack on the last allowed fetch wait cycle: no fault
    plan(0, 1, 0, T - 1, 0, 0);  run_queue("fetch_ack_last", 0, ended);
    // Same two boundaries on a data access
    plan(1, 1, 0, 0, T - 1, 0);  run_queue("mem_ack_last", 0, ended);
    plan(2, 0, 0, 0, T, 0);      run_queue("mem_timeout", 0, ended);
    do_reset();
    // Run gate low for five cycles in EXECUTE and in a pending FETCH
    plan(2, 0, 1, 2, 1, 0);  run_queue("enable_gap", 2, ended);
    // Halt request in WRITEBACK: instruction still retires
    plan(1, 1, 0, 1, 0, 1);  run_queue("halt", 0, ended);
    do_reset();
    // Retired-count wrap from 0xFFFF
    force dut.r_retired = 16'hFFFF;
    #1;
    release dut.r_retired;
    m_retired = 16'hFFFF;
    plan(0, 1, 0, 0, 0, 0);  run_queue("wrap", 0, ended);
    plan(0, 1, 1, 1, 0, 0);  run_queue("after_wrap", 0, ended);
    // Reset in the middle of a pending fetch: request drops next cycle
    plan(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      r = q.pop_front();
      apply(r, 0, "mid_reset");
    end
    q.delete();
    do_reset();

    // Random instruction mix with random run-gate gaps
    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 3);
      df   = ($urandom_range(0, 24) == 0) ? T : int'($urandom_range(0, T - 1));
      dm   = ($urandom_range(0, 24) == 0) ? T : int'($urandom_range(0, T - 1));
      plan(mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), df, dm,
           ($urandom_range(0, 29) == 0));
      run_queue("random", 1, ended);
      if (ended) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
